// File: rtl/moore_pattern_tx_pkg.sv
// Shared state encoding and counter-width helpers for the pattern transmitter.
package moore_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed for a down-counter holding n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/moore_pattern_tx_piso_shift_reg.sv
// Parallel-load, shift-left register exposing its MSB; load wins over shift.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             R,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Register contents: reset, parallel load, or shift toward the MSB.
  always_ff @(posedge clk) begin
    if (R) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, optionally
// repeated with idle gaps, with registered Moore-style status outputs.
module moore_pattern_tx
  import moore_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = cnt_w(WIDTH);
  localparam int unsigned GAP_W = cnt_w(GAP);

  state_t           state, state_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [REP_W-1:0] rep_left, rep_left_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic             load, shift;
  logic [WIDTH-1:0] load_d;
  logic             msb;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .R     (R),
    .load  (load),
    .shift (shift),
    .d     (load_d),
    .msb   (msb)
  );

  // Next-state, counter updates and shift-register control.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    rep_left_n = rep_left;
    shadow_n   = shadow;
    load       = 1'b0;
    shift      = 1'b0;
    load_d     = shadow;
    case (state)
      ST_IDLE: begin
        if (start) begin
          shadow_n   = pattern;
          load       = 1'b1;
          load_d     = pattern;
          rep_left_n = (repeat_n == '0) ? REP_W'(1) : repeat_n;
          bit_cnt_n  = BIT_W'(WIDTH - 1);
          state_n    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt == '0) begin
          if (rep_left > REP_W'(1)) begin
            // Reload from the shadow copy; load overrides the shift this edge.
            rep_left_n = rep_left - REP_W'(1);
            load       = 1'b1;
            if (GAP == 0) begin
              bit_cnt_n = BIT_W'(WIDTH - 1);
            end else begin
              gap_cnt_n = GAP_W'(GAP - 1);
              state_n   = ST_GAP;
            end
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          bit_cnt_n = bit_cnt - BIT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          bit_cnt_n = BIT_W'(WIDTH - 1);
          state_n   = ST_SHIFT;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and status flags; flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (R) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rep_left <= '0;
      shadow   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      rep_left <= rep_left_n;
      shadow   <= shadow_n;
      valid    <= (state_n == ST_SHIFT);
      busy     <= (state_n == ST_SHIFT) || (state_n == ST_GAP);
      done     <= (state_n == ST_DONE);
    end
  end

  // Both operands are flops, so out only moves on clock edges and is 0 off-SHIFT.
  assign out = valid & msb;

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Directed bench for moore_pattern_tx (GAP=1 instance plus a GAP=0 instance).
module tb_moore_pattern_tx;

  logic       clk;
  logic       R;
  logic       start;
  logic       start0;
  logic [7:0] pattern;
  logic [3:0] repeat_n;
  logic       out, valid, busy, done;
  logic       out0, valid0, busy0, done0;

  int total;
  int bad;

  moore_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(1)) dut (
    .clk(clk), .R(R), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .out(out), .valid(valid), .busy(busy), .done(done)
  );

  moore_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(0)) dut0 (
    .clk(clk), .R(R), .start(start0), .pattern(pattern), .repeat_n(repeat_n),
    .out(out0), .valid(valid0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {out,valid,busy,done} in cycle c, where cycle 1 follows the accept edge.
  function automatic logic [3:0] model(input logic [7:0] pat, input int rep,
                                       input int gap, input int c);
    int pos, period, tot, k;
    pos    = c - 1;
    period = 8 + gap;
    tot    = rep * 8 + (rep - 1) * gap;
    if (pos < 0) return 4'b0000;
    if (pos < tot) begin
      k = pos % period;
      if (k < 8) return {pat[7 - k], 3'b110};
      return 4'b0010;
    end
    if (pos == tot) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic test_reset();
    R = 1'b1; start = 1'b0; start0 = 1'b0; pattern = 8'hFF; repeat_n = 4'd1;
    step(); step();
    total++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL reset got=%b exp=0000", {out, valid, busy, done});
    end
    total++;
    if ({out0, valid0, busy0, done0} !== 4'b0000) begin
      bad++; $display("FAIL reset_gap0 got=%b exp=0000", {out0, valid0, busy0, done0});
    end
    R = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [3:0] exp;
    pattern = 8'b1011_0100; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp = model(8'b1011_0100, 1, 1, c);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL single c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      step();
    end
  endtask

  task automatic test_repeat();
    logic [3:0] exp;
    int busy_cnt;
    busy_cnt = 0;
    pattern = 8'hA5; repeat_n = 4'd3; start = 1'b1;
    step();
    start = 1'b0; pattern = 8'h00; repeat_n = 4'd1;
    for (int c = 1; c <= 29; c++) begin
      exp = model(8'hA5, 3, 1, c);
      if (busy) busy_cnt++;
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL repeat3 c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      step();
    end
    total++;
    if (busy_cnt !== 26) begin
      bad++; $display("FAIL repeat3_busy_cycles got=%0d exp=26", busy_cnt);
    end
  endtask

  task automatic test_repeat_zero();
    logic [3:0] exp;
    pattern = 8'h3C; repeat_n = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp = model(8'h3C, 1, 1, c);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL repeat0 c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      step();
    end
  endtask

  task automatic test_loopback_101();
    logic [2:0] win;
    int nbits, hits;
    win = '0; nbits = 0; hits = 0;
    pattern = 8'b1010_1000; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (valid) begin
        win = {win[1:0], out};
        nbits++;
        if (nbits >= 3 && win == 3'b101) hits++;
      end
      step();
    end
    total++;
    if (hits !== 2) begin
      bad++; $display("FAIL loopback_101 got=%0d exp=2", hits);
    end
  endtask

  task automatic test_ignore_start();
    logic [3:0] exp;
    pattern = 8'b1011_0100; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp = model(8'b1011_0100, 1, 1, c);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL ignore_start c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      if (c == 4) begin start = 1'b1; pattern = 8'h0F; repeat_n = 4'd2; end
      if (c == 5) begin start = 1'b0; pattern = 8'b1011_0100; repeat_n = 4'd1; end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    pattern = 8'b1011_0100; repeat_n = 4'd1; start = 1'b1;
    step();
    for (int c = 1; c <= 21; c++) begin
      if (c <= 10) exp = model(8'b1011_0100, 1, 1, c);
      else         exp = model(8'b1011_0100, 1, 1, c - 10);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL back_to_back c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      if (c == 11) start = 1'b0;
      step();
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp;
    int done_seen;
    done_seen = 0;
    pattern = 8'b1011_0100; repeat_n = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = model(8'b1011_0100, 2, 1, c);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL abort_pre c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      if (c == 5) R = 1'b1;
      step();
    end
    R = 1'b0;
    for (int c = 6; c <= 25; c++) begin
      if (done) done_seen++;
      total++;
      if ({out, valid, busy} !== 3'b000) begin
        bad++; $display("FAIL abort_post c=%0d got=%b exp=000", c, {out, valid, busy});
      end
      step();
    end
    total++;
    if (done_seen !== 0) begin
      bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    end
    pattern = 8'b1011_0100; repeat_n = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp = model(8'b1011_0100, 1, 1, c);
      total++;
      if ({out, valid, busy, done} !== exp) begin
        bad++; $display("FAIL abort_restart c=%0d got=%b exp=%b", c, {out, valid, busy, done}, exp);
      end
      step();
    end
  endtask

  task automatic test_gap0();
    logic [3:0] exp;
    int valid_run;
    valid_run = 0;
    pattern = 8'hFF; repeat_n = 4'd2; start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      exp = model(8'hFF, 2, 0, c);
      if (valid0 && out0) valid_run++;
      total++;
      if ({out0, valid0, busy0, done0} !== exp) begin
        bad++; $display("FAIL gap0 c=%0d got=%b exp=%b", c, {out0, valid0, busy0, done0}, exp);
      end
      step();
    end
    total++;
    if (valid_run !== 16) begin
      bad++; $display("FAIL gap0_valid_ones got=%0d exp=16", valid_run);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_repeat();
    test_repeat_zero();
    test_loopback_101();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_gap0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
